// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Misses refill the line from backing memory and stores are written through; both stall the CPU.
module data_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic                  cpu_byte,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  stall,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  mem_byte,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } state_e;

  state_e                  state_r;
  state_e                  nextState_s;
  logic [1:0]              cnt_r;
  logic [LINES-1:0]        valid_r;
  logic [TAG_W-1:0]        tag_r  [LINES];
  logic [DATA_WIDTH-1:0]   data_r [LINES*4];

  logic [IDX_W-1:0]        idx_s;
  logic [TAG_W-1:0]        addrTag_s;
  logic [1:0]              word_s;
  logic [DATA_WIDTH-1:0]   lineWord_s;
  logic [DATA_WIDTH-1:0]   storeWord_s;
  logic                    hit_s;

  function automatic logic [7:0] pickByte(input logic [31:0] w, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] mergeByte(input logic [31:0] w, input logic [7:0] b,
                                            input logic [1:0] lane);
    logic [31:0] r;
    r = w;
    case (lane)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      2'd3:    r[31:24] = b;
      default: r = w;
    endcase
    return r;
  endfunction

  assign idx_s       = cpu_addr[IDX_W+3:4];
  assign addrTag_s   = cpu_addr[31:IDX_W+4];
  assign word_s      = cpu_addr[3:2];
  assign lineWord_s  = data_r[{idx_s, word_s}];
  assign hit_s       = valid_r[idx_s] && (tag_r[idx_s] == addrTag_s);
  assign storeWord_s = cpu_byte ? mergeByte(lineWord_s, cpu_wdata[7:0], cpu_addr[1:0]) : cpu_wdata;

  // State, refill beat counter and line valid bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 2'd0;
      valid_r <= {LINES{1'b0}};
    end else begin
      state_r <= nextState_s;
      case (state_r)
        IDLE: begin
          // The line is invalidated up front so an abandoned refill never looks valid.
          if (!cpu_we && cpu_re && !hit_s) begin
            valid_r[idx_s] <= 1'b0;
            cnt_r          <= 2'd0;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            cnt_r <= cnt_r + 2'd1;
            if (cnt_r == 2'd3) begin
              valid_r[idx_s] <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Line data and tag storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      case (state_r)
        REFILL: begin
          if (mem_ready) begin
            data_r[{idx_s, cnt_r}] <= mem_rdata;
            if (cnt_r == 2'd3) begin
              tag_r[idx_s] <= addrTag_s;
            end
          end
        end
        WRITE: begin
          if (mem_ready && hit_s) begin
            data_r[{idx_s, word_s}] <= storeWord_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next state, CPU-side response and memory request; everything is quiet while in reset.
  always_comb begin
    nextState_s = state_r;
    stall       = 1'b0;
    cpu_rdata   = {DATA_WIDTH{1'b0}};
    mem_addr    = 32'd0;
    mem_wdata   = {DATA_WIDTH{1'b0}};
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_byte    = 1'b0;
    if (!rst) begin
      nextState_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (cpu_we) begin
            stall       = 1'b1;
            nextState_s = WRITE;
          end else if (cpu_re) begin
            if (hit_s) begin
              cpu_rdata = cpu_byte ? {24'd0, pickByte(lineWord_s, cpu_addr[1:0])} : lineWord_s;
            end else begin
              stall       = 1'b1;
              nextState_s = REFILL;
            end
          end else begin
            nextState_s = IDLE;
          end
        end
        REFILL: begin
          stall    = 1'b1;
          mem_rd   = 1'b1;
          mem_addr = {cpu_addr[31:4], cnt_r, 2'b00};
          if (mem_ready && (cnt_r == 2'd3)) begin
            nextState_s = IDLE;
          end else begin
            nextState_s = REFILL;
          end
        end
        WRITE: begin
          mem_wr    = 1'b1;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          mem_byte  = cpu_byte;
          // Releasing the stall on the accept cycle makes the store retire exactly once.
          stall     = !mem_ready;
          if (mem_ready) begin
            nextState_s = IDLE;
          end else begin
            nextState_s = WRITE;
          end
        end
        default: begin
          nextState_s = IDLE;
        end
      endcase
    end
  end

endmodule
